// File: rtl/sync_fifo_param_pkg.sv
// Shared definitions for the parametrised synchronous FIFO family:
// default geometry, occupancy-update encoding and elaboration-time helpers
// that the future asynchronous FIFO will reuse.
package sync_fifo_param_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_DEPTH  = 16;

   // Which of the two ports actually completed an operation this cycle.
   // The encoding is {write accepted, read accepted}.
   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_BOTH = 2'b11
   } fifo_op_e;

   // Ceiling log2, usable in constant expressions.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((32'sd1 <<< result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

   // Returns 1 when the almost-full and almost-empty thresholds are in range.
   function automatic bit thresh_ok(input int depth, input int af_thresh, input int ae_thresh);
      return (af_thresh >= 1) && (af_thresh <= depth) &&
             (ae_thresh >= 0) && (ae_thresh <= depth - 1);
   endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer-side signal bundle of the synchronous FIFO.
// The master modport is the user of the FIFO, the slave modport is the FIFO.
interface sync_fifo_param_if
   import sync_fifo_param_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = clog2(DEF_DEPTH)
) ();

   logic              wr;
   logic [DATA_W-1:0] datain;
   logic              rd;
   logic [DATA_W-1:0] dataout;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic              almost_empty;
   logic [ADDR_W:0]   count;
   logic              err_clr;
   logic              ovf;
   logic              udf;

   modport master (
      output wr, datain, rd, err_clr,
      input  dataout, full, empty, almost_full, almost_empty, count, ovf, udf
   );

   modport slave (
      input  wr, datain, rd, err_clr,
      output dataout, full, empty, almost_full, almost_empty, count, ovf, udf
   );

endinterface

// File: rtl/fifo_mem_2p.sv
// Two-port FIFO storage: synchronous write port, asynchronous read port.
// Contents are deliberately not reset.
module fifo_mem_2p
   import sync_fifo_param_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int ADDR_W = clog2(DEF_DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   // Store the write word at the write address on an accepted write.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock first-word-fall-through FIFO with occupancy
// count, programmable almost-full/almost-empty and sticky overflow/underflow
// flags. Holds pointers, count, flags and errors; storage is fifo_mem_2p.
module sync_fifo_param
   import sync_fifo_param_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int ADDR_W    = 4,
   parameter int AF_THRESH = 14,
   parameter int AE_THRESH = 2
) (
   input  logic              clk,
   input  logic              rst,
   sync_fifo_param_if.slave  fif
);

   // Geometry and threshold sanity, caught at elaboration.
   if (ADDR_W != clog2(DEPTH) || (1 << ADDR_W) != DEPTH || DEPTH < 4) begin : g_bad_geometry
      $error("sync_fifo_param: DEPTH must be a power of two >= 4 and ADDR_W = log2(DEPTH)");
   end
   if (!thresh_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_thresh
      $error("sync_fifo_param: AF_THRESH/AE_THRESH out of range");
   end

   localparam logic [ADDR_W:0] LP_ONE   = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W:0] LP_ZERO  = {(ADDR_W+1){1'b0}};
   localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] LP_AF    = (ADDR_W+1)'(AF_THRESH);
   localparam logic [ADDR_W:0] LP_AE    = (ADDR_W+1)'(AE_THRESH);

   logic [ADDR_W:0]   r_wp;
   logic [ADDR_W:0]   r_rp;
   logic [ADDR_W:0]   r_count;
   logic              r_full;
   logic              r_empty;
   logic              r_almost_full;
   logic              r_almost_empty;
   logic              r_ovf;
   logic              r_udf;

   logic              w_wr_ok;
   logic              w_rd_ok;
   logic              w_mem_we;
   logic              w_ovf_nxt;
   logic              w_udf_nxt;
   logic [ADDR_W:0]   w_count_nxt;
   fifo_op_e          w_op;
   logic [DATA_W-1:0] w_rdata;

   // Acceptance from pre-edge flags, next occupancy and next sticky errors.
   always_comb begin
      w_wr_ok     = 1'b0;
      w_rd_ok     = 1'b0;
      w_op        = OP_IDLE;
      w_count_nxt = r_count;
      w_ovf_nxt   = r_ovf;
      w_udf_nxt   = r_udf;

      w_wr_ok = fif.wr & ~r_full;
      w_rd_ok = fif.rd & ~r_empty;
      w_op    = fifo_op_e'({w_wr_ok, w_rd_ok});

      case (w_op)
         OP_PUSH: w_count_nxt = r_count + LP_ONE;
         OP_POP:  w_count_nxt = r_count - LP_ONE;
         default: w_count_nxt = r_count;
      endcase

      // A new error event outranks a same-cycle clear.
      w_ovf_nxt = (fif.wr & r_full)  | (r_ovf & ~fif.err_clr);
      w_udf_nxt = (fif.rd & r_empty) | (r_udf & ~fif.err_clr);
   end

   // An edge that lands while reset is held must not commit the write.
   assign w_mem_we = w_wr_ok & rst;

   // Pointers, occupancy, flags derived from next occupancy, sticky errors.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wp           <= LP_ZERO;
         r_rp           <= LP_ZERO;
         r_count        <= LP_ZERO;
         r_full         <= 1'b0;
         r_empty        <= 1'b1;
         r_almost_full  <= 1'b0;
         r_almost_empty <= 1'b1;
         r_ovf          <= 1'b0;
         r_udf          <= 1'b0;
      end else begin
         if (w_wr_ok) begin
            r_wp <= r_wp + LP_ONE;
         end
         if (w_rd_ok) begin
            r_rp <= r_rp + LP_ONE;
         end
         r_count        <= w_count_nxt;
         r_full         <= (w_count_nxt == LP_DEPTH);
         r_empty        <= (w_count_nxt == LP_ZERO);
         r_almost_full  <= (w_count_nxt >= LP_AF);
         r_almost_empty <= (w_count_nxt <= LP_AE);
         r_ovf          <= w_ovf_nxt;
         r_udf          <= w_udf_nxt;
      end
   end

   fifo_mem_2p #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .i_clk   (clk),
      .i_we    (w_mem_we),
      .i_waddr (r_wp[ADDR_W-1:0]),
      .i_wdata (fif.datain),
      .i_raddr (r_rp[ADDR_W-1:0]),
      .o_rdata (w_rdata)
   );

   assign fif.dataout      = w_rdata;
   assign fif.count        = r_count;
   assign fif.full         = r_full;
   assign fif.empty        = r_empty;
   assign fif.almost_full  = r_almost_full;
   assign fif.almost_empty = r_almost_empty;
   assign fif.ovf          = r_ovf;
   assign fif.udf          = r_udf;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param (8 x 16, AF=14, AE=2).
// A queue holds the words expected at the head; flags and count are
// predicted from the queue occupancy and a small sticky-error model.
module tb_sync_fifo_param;
   import sync_fifo_param_pkg::*;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic clk;
   logic rst;

   int checks;
   int errors;

   logic [DW-1:0] sb_q[$];
   logic          m_ovf;
   logic          m_udf;

   sync_fifo_param_if #(.DATA_W(DW), .ADDR_W(AW)) fif ();

   sync_fifo_param #(
      .DATA_W    (DW),
      .DEPTH     (DEPTH),
      .ADDR_W    (AW),
      .AF_THRESH (14),
      .AE_THRESH (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .fif (fif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Compare every observable output against the model.
   task automatic check_state(input string tag);
      int n;
      n = sb_q.size();
      chk({tag, ".count"}, 32'(fif.count), 32'(n));
      chk({tag, ".empty"}, 32'(fif.empty), 32'(n == 0));
      chk({tag, ".full"},  32'(fif.full),  32'(n == DEPTH));
      chk({tag, ".afull"}, 32'(fif.almost_full),  32'(n >= 14));
      chk({tag, ".aempty"}, 32'(fif.almost_empty), 32'(n <= 2));
      chk({tag, ".ovf"},   32'(fif.ovf), 32'(m_ovf));
      chk({tag, ".udf"},   32'(fif.udf), 32'(m_udf));
      if (n > 0) begin
         chk({tag, ".head"}, 32'(fif.dataout), 32'(sb_q[0]));
      end
   endtask

   // One clock of stimulus; called at posedge+1, returns at next posedge+1.
   task automatic step(input string tag, input logic w, input logic [DW-1:0] d,
                       input logic r, input logic c);
      int  pre_cnt;
      logic wr_ok;
      logic [DW-1:0] exp_word;
      fif.wr      = w;
      fif.datain  = d;
      fif.rd      = r;
      fif.err_clr = c;
      pre_cnt = sb_q.size();
      wr_ok   = w && (pre_cnt < DEPTH);
      if (r && pre_cnt > 0) begin
         exp_word = sb_q.pop_front();
         chk({tag, ".pop"}, 32'(fif.dataout), 32'(exp_word));
      end
      m_ovf = (w && pre_cnt == DEPTH) || (m_ovf && !c);
      m_udf = (r && pre_cnt == 0)     || (m_udf && !c);
      @(posedge clk);
      #1;
      if (wr_ok) sb_q.push_back(d);
      fif.wr      = 1'b0;
      fif.rd      = 1'b0;
      fif.err_clr = 1'b0;
      check_state(tag);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      rst         = 1'b0;
      fif.wr      = 1'b0;
      fif.rd      = 1'b0;
      fif.err_clr = 1'b0;
      fif.datain  = '0;

      // 1: reset then idle
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_state("reset");
      step("idle", 1'b0, 8'h00, 1'b0, 1'b0);

      // 2: fill 0x00..0x0F, then drain in order
      for (int i = 0; i < 16; i++) step("fill", 1'b1, 8'(i), 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0);

      // 3: overflow attempt, 0xAA must never surface, then clear
      for (int i = 0; i < 16; i++) step("fill3", 1'b1, 8'(i), 1'b0, 1'b0);
      step("ovf", 1'b1, 8'hAA, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step("rd3", 1'b0, 8'h00, 1'b1, 1'b0);
      step("ovf_clr", 1'b0, 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < 13; i++) step("drain3", 1'b0, 8'h00, 1'b1, 1'b0);

      // 4: underflow, then simultaneous wr&rd on empty
      step("udf", 1'b0, 8'h00, 1'b1, 1'b0);
      step("wr_rd_empty", 1'b1, 8'h55, 1'b1, 1'b0);
      chk("head55", 32'(fif.dataout), 32'h55);
      step("udf_clr", 1'b0, 8'h00, 1'b0, 1'b1);
      step("pop55", 1'b0, 8'h00, 1'b1, 1'b0);

      // 5: steady state at count 8 while pointers wrap
      for (int i = 0; i < 8; i++) step("fill5", 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) step("stream", 1'b1, 8'(8'h20 + i), 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) step("drain5", 1'b0, 8'h00, 1'b1, 1'b0);

      // 6: reset mid-burst at count 9 with a write in flight
      for (int i = 0; i < 9; i++) step("fill6", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
      fif.wr     = 1'b1;
      fif.datain = 8'h99;
      rst        = 1'b0;
      #1;
      sb_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      check_state("rst_async");
      @(posedge clk);
      #1;
      check_state("rst_edge");
      fif.wr = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_state("rst_release");
      step("wr_after_rst", 1'b1, 8'h77, 1'b0, 1'b0);
      chk("head77", 32'(fif.dataout), 32'h77);
      step("rd_after_rst", 1'b0, 8'h00, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
